mac_pipe_vec: RTL and testbench
===============================

Name: mac_pipe_vec

Overview:
Parameterised multi-lane successor to the single-lane pipelined MAC unit.
- Each valid cycle it multiplies LANES signed operand pairs and sums them through a registered adder stage.
- It then accumulates that lane sum into one OUTW-bit accumulator, with optional saturation.
- It is the compute core of the 2D convolution datapath: one kernel row or channel group per input beat.
- Control (init_acc, input_valid) comes from the convolution controller FSM.

Parameters:
- INW, 16, signed operand width per lane.
- OUTW, 64, accumulator and output width. Constraint: OUTW >= 2*INW + clog2(LANES), otherwise elaboration error.
- LANES, 4, number of parallel multiplier lanes (>=1).
- SATURATE, 0. 0 = two's-complement wrap; 1 = clamp accumulator to signed OUTW range.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- input_valid  input  1  new operands on in_a/in_b/lane_mask this cycle.
- init_acc  input  1  load accumulator with init_value (synchronous).
- init_value  input  OUTW  signed accumulator initial value.
- in_a  input  LANES*INW  packed signed operands; lane k = bits [k*INW +: INW].
- in_b  input  LANES*INW  packed signed operands; same packing as in_a.
- lane_mask  input  LANES  1 = lane contributes; 0 = lane product forced to 0.
- out  output  OUTW  signed accumulator value.
- out_valid  output  1  one-cycle pulse: out updated by an accumulate this cycle.
- busy  output  1  any valid beat in stage 1 or stage 2.
- overflow  output  1  sticky: accumulate overflowed or saturated since last init/reset.

Behaviour:
- Reset: all pipeline registers, valid bits, out, out_valid and overflow go to 0. Reset overrides every other input, including mid-operation; in-flight beats are discarded.
- Stage 1 (edge E0, when input_valid=1):
  - prod[k] <= lane_mask[k] ? a[k]*b[k] : 0, full 2*INW-bit signed.
  - v1 <= 1.
  - When input_valid=0: v1 <= 0 and prod holds.
- Stage 2 (edge E1, when v1=1):
  - sum <= sign-extended sum of all prod[k], width 2*INW+clog2(LANES); cannot overflow.
  - v2 <= v1.
- Stage 3 (accumulate, edge E2):
  - When init_acc=1: out <= init_value; overflow <= 0; out_valid <= 0. Any beat at stage 3 that cycle (v2=1) is dropped.
  - Else when v2=1: out <= out + sign-extended sum; out_valid <= 1.
  - Else: out holds; out_valid <= 0.
- Latency: inputs sampled at E0 are reflected in out after E2 (2 cycles).
- Throughput: one beat per cycle, no backpressure.
- init_acc is independent of stages 1/2. Beats accepted at or after the init cycle still flow through and accumulate on top of init_value.
- Overflow detection: signed overflow when the true OUTW+1-bit result falls outside [-2^(OUTW-1), 2^(OUTW-1)-1].
  - SATURATE=0: result wraps; overflow <= 1.
  - SATURATE=1: out clamps to the bound (max for positive overflow, min for negative); overflow <= 1.
  - overflow stays set until init_acc or reset.
- busy = v1 | v2, combinational from registers.
- lane_mask=0 with input_valid=1 still produces a beat: it adds 0 and pulses out_valid.

Test Plan:
1. Reset mid-stream. Defaults; feed 3 back-to-back beats, assert reset on the 2nd beat's following cycle.
   -> out=0, out_valid=0, busy=0 next cycle; no later accumulates.
2. Basic dot product. init_acc with init_value=10; next cycle one beat, lanes a={1,2,3,4}, b={5,6,7,8}, mask=4'b1111.
   -> out=80 two edges after the beat, out_valid pulse exactly 1 cycle, busy high 2 cycles.
3. Back-to-back beats with signed values and a mask. Beats a={-3,0,0,0} b={7,...} (lane 0 only), then a={2,2,2,2} b={-1,-1,-1,-1} with mask=4'b0011.
   -> out sequence after init 0: -21, then -25.
4. init collision. A beat at stage 3 in the same cycle as init_acc=1 (init_value=100), with a second beat (product sum 6) one cycle behind it.
   -> out=100, then 106; the colliding beat is lost.
5. Saturation. OUTW=34, SATURATE=1; all lanes a=b=-32768 (sum 2^32) for 2 beats from init 0.
   -> out=4294967296, then clamps at 8589934591; overflow=1 until next init_acc.
6. Wrap mode. Same stimulus as scenario 5 with SATURATE=0.
   -> second result wraps to -8589934592; overflow=1.

Source files
------------

// File: rtl/mac_pipe_vec.sv
// Multi-lane pipelined MAC: per-lane signed multiply, registered lane-sum adder,
// then a single OUTW-bit accumulator with optional saturation and sticky overflow.

module mac_pipe_vec_lane #(
   parameter int INW = 16,
   parameter int PW  = 2*INW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en_i,
   input  logic                 mask_i,
   input  logic signed [INW-1:0] a_i,
   input  logic signed [INW-1:0] b_i,
   output logic signed [PW-1:0]  prod_o
);
   logic signed [PW-1:0] prod_q, prod_d, mul;

   // Extend before multiplying so the full-width product is formed.
   assign mul = PW'(a_i) * PW'(b_i);

   always_comb begin
      prod_d = prod_q;
      if (en_i) prod_d = mask_i ? mul : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) prod_q <= '0;
      else       prod_q <= prod_d;
   end

   assign prod_o = prod_q;
endmodule

module mac_pipe_vec #(
   parameter int INW      = 16,
   parameter int OUTW     = 64,
   parameter int LANES    = 4,
   parameter int SATURATE = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       input_valid,
   input  logic                       init_acc,
   input  logic signed [OUTW-1:0]     init_value,
   input  logic [LANES*INW-1:0]       in_a,
   input  logic [LANES*INW-1:0]       in_b,
   input  logic [LANES-1:0]           lane_mask,
   output logic signed [OUTW-1:0]     out,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       overflow
);
   localparam int PW   = 2*INW;
   localparam int SUMW = PW + $clog2(LANES);
   localparam bit SAT  = (SATURATE != 0);

   generate
      if (LANES < 1)    begin : g_bad_lanes $error("mac_pipe_vec: LANES must be >= 1"); end
      if (OUTW < SUMW)  begin : g_bad_outw  $error("mac_pipe_vec: OUTW too narrow for lane sum"); end
   endgenerate

   logic [LANES-1:0][PW-1:0] prods;
   logic [2:1]               vld_pipe_q, vld_pipe_d;

   genvar k;
   generate
      for (k = 0; k < LANES; k++) begin : g_lane
         mac_pipe_vec_lane #(.INW(INW), .PW(PW)) u_lane (
            .clk    (clk),
            .reset  (reset),
            .en_i   (input_valid),
            .mask_i (lane_mask[k]),
            .a_i    (in_a[k*INW +: INW]),
            .b_i    (in_b[k*INW +: INW]),
            .prod_o (prods[k])
         );
      end
   endgenerate

   assign vld_pipe_d = {vld_pipe_q[1], input_valid};

   // Stage 2: lane sum is wide enough that it can never overflow.
   logic signed [SUMW-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (vld_pipe_q[1]) begin
         sum_d = '0;
         for (int i = 0; i < LANES; i++) sum_d = sum_d + SUMW'($signed(prods[i]));
      end
   end

   // Stage 3: one extra bit exposes signed overflow of the accumulate.
   localparam logic signed [OUTW-1:0] MAXV = {1'b0, {(OUTW-1){1'b1}}};
   localparam logic signed [OUTW-1:0] MINV = {1'b1, {(OUTW-1){1'b0}}};

   logic signed [OUTW:0]   acc_full;
   logic                   acc_ovf;
   logic signed [OUTW-1:0] acc_res;
   logic signed [OUTW-1:0] out_q, out_d;
   logic                   outv_q, outv_d, ovf_q, ovf_d;

   assign acc_full = (OUTW+1)'(out_q) + (OUTW+1)'(sum_q);
   assign acc_ovf  = acc_full[OUTW] ^ acc_full[OUTW-1];

   always_comb begin
      acc_res = acc_full[OUTW-1:0];
      if (SAT && acc_ovf) acc_res = acc_full[OUTW] ? MINV : MAXV;
   end

   always_comb begin
      out_d  = out_q;
      ovf_d  = ovf_q;
      outv_d = 1'b0;
      if (init_acc) begin
         out_d = init_value;
         ovf_d = 1'b0;
      end else if (vld_pipe_q[2]) begin
         out_d  = acc_res;
         outv_d = 1'b1;
         if (acc_ovf) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe_q <= '0;
         sum_q      <= '0;
         out_q      <= '0;
         outv_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         sum_q      <= sum_d;
         out_q      <= out_d;
         outv_q     <= outv_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out       = out_q;
   assign out_valid = outv_q;
   assign overflow  = ovf_q;
   assign busy      = |vld_pipe_q;
endmodule

// File: tb/tb_mac_pipe_vec.sv
// Directed bench for mac_pipe_vec: a default 64-bit instance plus 34-bit
// saturating and wrapping instances sharing one stimulus stream.

module tb_mac_pipe_vec;
   logic        clk = 1'b0;
   logic        reset, input_valid, init_acc;
   logic [63:0] init_value, in_a, in_b;
   logic [3:0]  lane_mask;

   logic signed [63:0] out0;
   logic signed [33:0] out_s, out_w;
   logic v0, vs, vw, b0, bs, bw, o0, os, ow;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mac_pipe_vec u_dut (
      .clk(clk), .reset(reset), .input_valid(input_valid), .init_acc(init_acc),
      .init_value(init_value), .in_a(in_a), .in_b(in_b), .lane_mask(lane_mask),
      .out(out0), .out_valid(v0), .busy(b0), .overflow(o0));

   mac_pipe_vec #(.OUTW(34), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .input_valid(input_valid), .init_acc(init_acc),
      .init_value(init_value[33:0]), .in_a(in_a), .in_b(in_b), .lane_mask(lane_mask),
      .out(out_s), .out_valid(vs), .busy(bs), .overflow(os));

   mac_pipe_vec #(.OUTW(34), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .input_valid(input_valid), .init_acc(init_acc),
      .init_value(init_value[33:0]), .in_a(in_a), .in_b(in_b), .lane_mask(lane_mask),
      .out(out_w), .out_valid(vw), .busy(bw), .overflow(ow));

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pk(input int x0, input int x1, input int x2, input int x3);
      logic [15:0] e0, e1, e2, e3;
      e0 = x0[15:0]; e1 = x1[15:0]; e2 = x2[15:0]; e3 = x3[15:0];
      return {e3, e2, e1, e0};
   endfunction

   task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m);
      input_valid = 1'b1; in_a = a; in_b = b; lane_mask = m;
   endtask

   task automatic idle();
      input_valid = 1'b0; init_acc = 1'b0;
   endtask

   task automatic do_init(input logic signed [63:0] v);
      input_valid = 1'b0; init_acc = 1'b1; init_value = v;
      tick();
      init_acc = 1'b0;
   endtask

   initial begin
      reset = 1'b1; input_valid = 1'b0; init_acc = 1'b0; init_value = '0;
      in_a = '0; in_b = '0; lane_mask = '0;
      tick(); tick();
      chk("rst_out", out0, 0);
      chk("rst_valid", v0, 0);
      chk("rst_busy", b0, 0);
      chk("rst_ovf", o0, 0);
      reset = 1'b0;

      // reset lands while beats are in flight; nothing may surface afterwards
      beat(pk(1,1,1,1), pk(1,1,1,1), 4'hF); tick();
      beat(pk(2,2,2,2), pk(3,3,3,3), 4'hF); tick();
      beat(pk(5,5,5,5), pk(5,5,5,5), 4'hF); reset = 1'b1; tick();
      reset = 1'b0; idle();
      chk("midrst_out", out0, 0);
      chk("midrst_valid", v0, 0);
      chk("midrst_busy", b0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst_hold_out", out0, 0);
         chk("midrst_hold_valid", v0, 0);
      end

      // basic dot product on top of init 10
      do_init(10);
      chk("init10_out", out0, 10);
      beat(pk(1,2,3,4), pk(5,6,7,8), 4'hF); tick();
      idle();
      chk("dot_busy1", b0, 1);
      chk("dot_valid0", v0, 0);
      tick();
      chk("dot_busy2", b0, 1);
      chk("dot_out_pre", out0, 10);
      tick();
      chk("dot_out", out0, 80);
      chk("dot_valid1", v0, 1);
      chk("dot_busy3", b0, 0);
      tick();
      chk("dot_valid_pulse", v0, 0);
      chk("dot_out_hold", out0, 80);

      // signed values and partial mask, back-to-back
      do_init(0);
      beat(pk(-3,0,0,0), pk(7,7,7,7), 4'hF); tick();
      beat(pk(2,2,2,2), pk(-1,-1,-1,-1), 4'b0011); tick();
      idle(); tick();
      chk("sgn_out1", out0, -21);
      chk("sgn_valid1", v0, 1);
      tick();
      chk("sgn_out2", out0, -25);
      chk("sgn_valid2", v0, 1);
      tick();
      chk("sgn_valid3", v0, 0);

      // masked-out beat still produces a pulse, adds nothing
      beat(pk(9,9,9,9), pk(9,9,9,9), 4'b0000); tick();
      idle(); tick(); tick();
      chk("mask0_out", out0, -25);
      chk("mask0_valid", v0, 1);

      // init collides with a beat at stage 3; next beat lands on init value
      beat(pk(10,10,10,10), pk(10,10,10,10), 4'hF); tick();
      beat(pk(1,1,1,1), pk(1,2,3,0), 4'hF); tick();
      input_valid = 1'b0; init_acc = 1'b1; init_value = 100; tick();
      init_acc = 1'b0;
      chk("coll_out", out0, 100);
      chk("coll_valid", v0, 0);
      tick();
      chk("coll_out2", out0, 106);
      chk("coll_valid2", v0, 1);
      chk("coll_ovf", o0, 0);

      // 2^32 per beat: saturates / wraps on the 34-bit instances
      do_init(0);
      beat(pk(-32768,-32768,-32768,-32768), pk(-32768,-32768,-32768,-32768), 4'hF); tick();
      tick();
      idle(); tick();
      chk("big1_out64", out0, 64'sd4294967296);
      chk("big1_sat", out_s, 64'sd4294967296);
      chk("big1_wrap", out_w, 64'sd4294967296);
      chk("big1_ovf_sat", os, 0);
      tick();
      chk("big2_out64", out0, 64'sd8589934592);
      chk("big2_sat", out_s, 64'sd8589934591);
      chk("big2_wrap", out_w, -64'sd8589934592);
      chk("big2_ovf64", o0, 0);
      chk("big2_ovf_sat", os, 1);
      chk("big2_ovf_wrap", ow, 1);
      tick(); tick();
      chk("ovf_sticky_sat", os, 1);
      chk("ovf_sticky_wrap", ow, 1);
      do_init(5);
      chk("ovf_clr_sat", os, 0);
      chk("ovf_clr_wrap", ow, 0);
      chk("init5_sat", out_s, 5);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
